// File: rtl/qed_checker_if.sv
// Commit/register-file bus between a core and its SQED checker.
// The core side drives commits and register values; the checker reports status.
interface qed_checker_if #(
    parameter int NUM_REGS  = 32,
    parameter int DATA_LEN  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int NUM_PORTS = 2,
    parameter int CNT_W     = 16
);
    logic [NUM_REGS*DATA_LEN-1:0]  reg_vals;
    logic [NUM_PORTS-1:0]          arfwe;
    logic [NUM_PORTS*REG_SEL-1:0]  dstarf;
    logic                          check_en;
    logic                          qed_ready;
    logic                          qed_fail;
    logic [REG_SEL-1:0]            fail_idx;
    logic                          qed_done;
    logic [CNT_W-1:0]              num_orig_insts;
    logic [CNT_W-1:0]              num_dup_insts;
    logic [1:0]                    state;

    modport master (
        output reg_vals,
        output arfwe,
        output dstarf,
        output check_en,
        input  qed_ready,
        input  qed_fail,
        input  fail_idx,
        input  qed_done,
        input  num_orig_insts,
        input  num_dup_insts,
        input  state
    );

    modport slave (
        input  reg_vals,
        input  arfwe,
        input  dstarf,
        input  check_en,
        output qed_ready,
        output qed_fail,
        output fail_idx,
        output qed_done,
        output num_orig_insts,
        output num_dup_insts,
        output state
    );
endinterface

// File: rtl/qed_checker.sv
// SQED self-consistency checker: counts original/duplicate commits and
// latches the lowest inconsistent register pair when both halves agree in count.
module qed_checker #(
    parameter int NUM_REGS  = 32,
    parameter int DATA_LEN  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int NUM_PORTS = 2,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 0,
    parameter bit FORMAL    = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    qed_checker_if.slave bus
);
    localparam int HALF = NUM_REGS / 2;
    localparam int CW   = $clog2(NUM_PORTS + 1);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   orig_q;
    logic [CNT_W-1:0]   dup_q;
    logic [TW-1:0]      run_cnt_q;
    logic               fail_q;
    logic               done_q;
    logic [REG_SEL-1:0] fail_idx_q;

    logic [CW-1:0]      orig_c;
    logic [CW-1:0]      dup_c;
    logic               bad;
    logic [REG_SEL-1:0] bad_idx;
    logic               ready;
    logic               mismatch;
    logic               timeout_hit;

    // Destination 0 is the hard-wired zero register and never counts.
    always_comb begin
        orig_c = '0;
        dup_c  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.arfwe[p] &&
                bus.dstarf[p*REG_SEL +: REG_SEL] != '0) begin
                if (bus.dstarf[p*REG_SEL +: REG_SEL] < REG_SEL'(HALF)) begin
                    orig_c = orig_c + CW'(1);
                end else begin
                    dup_c = dup_c + CW'(1);
                end
            end
        end
    end

    // Scan downwards so the last hit is the lowest failing pair.
    always_comb begin
        bad     = 1'b0;
        bad_idx = '0;
        for (int i = HALF - 1; i >= 1; i--) begin
            if (bus.reg_vals[i*DATA_LEN +: DATA_LEN] !=
                bus.reg_vals[(i+HALF)*DATA_LEN +: DATA_LEN]) begin
                bad     = 1'b1;
                bad_idx = REG_SEL'(i);
            end
        end
        if (bus.reg_vals[DATA_LEN-1:0] != '0) begin
            bad     = 1'b1;
            bad_idx = '0;
        end
    end

    assign ready       = (state_q == RUN) && (orig_q == dup_q);
    assign mismatch    = ready && bad;
    assign timeout_hit = (TIMEOUT != 0) &&
                         (run_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            orig_q     <= '0;
            dup_q      <= '0;
            run_cnt_q  <= '0;
            fail_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.check_en) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    orig_q    <= orig_q + CNT_W'(orig_c);
                    dup_q     <= dup_q + CNT_W'(dup_c);
                    run_cnt_q <= run_cnt_q + TW'(1);
                    if (mismatch) begin
                        state_q    <= FAIL;
                        fail_q     <= 1'b1;
                        fail_idx_q <= bad_idx;
                    end else if (timeout_hit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.qed_ready      = ready;
    assign bus.qed_fail       = fail_q;
    assign bus.fail_idx       = fail_idx_q;
    assign bus.qed_done       = done_q;
    assign bus.num_orig_insts = orig_q;
    assign bus.num_dup_insts  = dup_q;
    assign bus.state          = state_q;

    if (FORMAL) begin : g_formal
        always_comb begin
            assume (rst_n);
            if (ready) begin
                qed_consistency: assert (!bad);
            end
        end
    end
endmodule

// File: doc/qed_checker.md
# qed_checker

Parametrised SQED self-consistency checker that sits beside the core, watching architectural-register commits and the register file. It generalises the fixed 32-register, 2-port property monitor to any even register count, any number of commit ports, an optional bounded run window and a sticky failure report with the first failing register index. It is usable in simulation (status outputs) and in formal (optional embedded assertion).

## Interface

- NUM_REGS, 32, architectural register count; even, ≥4; original half is 0..NUM_REGS/2-1, duplicate half is the rest
- DATA_LEN, 32, register width
- REG_SEL, $clog2(NUM_REGS), destination index width
- NUM_PORTS, 2, commit ports per cycle, 1..8
- CNT_W, 16, instruction counter width
- TIMEOUT, 0, RUN-cycle limit; 0 disables
- FORMAL, 0, 1 embeds immediate assertion `qed_consistency`
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reg_vals  in  NUM_REGS*DATA_LEN  flattened register file, reg i at [i*DATA_LEN +: DATA_LEN]
- arfwe  in  NUM_PORTS  per-port commit write enable
- dstarf  in  NUM_PORTS*REG_SEL  per-port destination, port p at [p*REG_SEL +: REG_SEL]
- check_en  in  1  start request, sampled only in IDLE
- qed_ready  out  1  counters equal and state RUN
- qed_fail  out  1  sticky mismatch flag
- fail_idx  out  REG_SEL  lowest mismatching original-half index
- qed_done  out  1  timeout reached without failure
- num_orig_insts  out  CNT_W  original-half commit count
- num_dup_insts  out  CNT_W  duplicate-half commit count
- state  out  2  IDLE=0, RUN=1, FAIL=2, DONE=3

## Operation

- Commit classification per port p, valid only when arfwe[p]=1: dst=0 is ignored; 0<dst<NUM_REGS/2 counts as original; dst≥NUM_REGS/2 counts as duplicate.
- Per-cycle totals orig_c and dup_c are sums over ports, width $clog2(NUM_PORTS+1), zero-extended to CNT_W.
- Counters advance only in RUN: num_orig_insts += orig_c, num_dup_insts += dup_c. Addition wraps modulo 2^CNT_W; no saturation.
- Consistency check: reg 0 must equal 0, and reg i must equal reg i+NUM_REGS/2 for 1≤i<NUM_REGS/2.
- mismatch is 1 when qed_ready=1 and the check fails. The minimum failing i is captured, with i=0 when reg 0 is nonzero.
- State machine:
  - IDLE→RUN when check_en=1.
  - RUN→FAIL on mismatch: qed_fail←1, fail_idx←minimum failing i.
  - RUN→DONE when TIMEOUT>0 and the RUN-cycle count equals TIMEOUT-1 with no mismatch in that cycle. Mismatch wins over timeout in the same cycle.
  - FAIL and DONE are terminal until reset.
- check_en is ignored outside IDLE.
- FORMAL=1: immediate assertion of the consistency condition whenever qed_ready=1, plus assumption rst_n=1 for generated models.

## Timing

- Reset values (async assert, sync-released on next edge): state=IDLE, counters=0, RUN-cycle counter=0, qed_fail=0, fail_idx=0, qed_done=0. Consequently qed_ready=0.
- qed_ready is combinational from registered counters and state. It is 1 in the first RUN cycle because the counters are 0.
- Commits presented in cycle t are visible in counters at t+1.
- Mismatch in cycle t gives qed_fail=1, state=FAIL and valid fail_idx at t+1; these hold until reset.
- Commits in the cycle of a RUN→FAIL/DONE transition are still counted. Counters freeze afterwards.
- Reset mid-RUN clears everything immediately, independent of clk.
- Register values are checked in the same cycle qed_ready is seen. Writes by commits in cycle t are checked from t+1.

## Test plan

- Reset then check_en=1, all regs 0, no commits → state=RUN, qed_ready=1 for 20 cycles, qed_fail=0.
- Defaults, port0 commits dst=3, next cycle port1 commits dst=19, regs 3 and 19 both 0x5A → qed_ready 0 for exactly one cycle, counters 1/1, no fail.
- Same cycle, port0 dst=5 and port1 dst=21; reg5=0x10, reg21=0x11 → counters 1/1, qed_ready=1, next cycle qed_fail=1, fail_idx=5, state=FAIL. Subsequent commits leave counters unchanged.
- reg0=1 and reg7≠reg23 with ready → fail_idx=0. dst=0 commits on both ports leave counters unchanged.
- TIMEOUT=12, consistent regs → state=DONE, qed_done=1 exactly 12 cycles after entering RUN. A mismatch injected on cycle 12 instead yields FAIL.
- NUM_REGS=16, NUM_PORTS=4, CNT_W=4, 16 orig and 16 dup commits → counters wrap to 0/0, qed_ready=1. rst_n pulsed low mid-RUN → all outputs reset asynchronously.
